// File: rtl/mips_load_store_unit_if.sv
// Request/response and data-memory bus of the MIPS load/store unit.
// The slave modport is the unit itself; master is the core plus memory side.
interface mips_load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_wr_en;
  logic        mem_read_en;
  logic [3:0]  mem_byte_en;
  logic [31:0] mem_wr_data;
  logic [31:0] mem_rd_data;

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rd_data,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_wr_en, mem_read_en, mem_byte_en, mem_wr_data
  );

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready, mem_rd_data,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_address, mem_wr_en, mem_read_en, mem_byte_en, mem_wr_data
  );
endinterface

// File: rtl/mips_load_store_unit.sv
// MIPS load/store unit: one request in flight, store lane steering, load extraction with
// sign/zero extension, and rejection of misaligned or out-of-range accesses before memory.
module mips_load_store_unit #(
  parameter int unsigned MEM_BYTES = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  mips_load_store_unit_if.slave bus
);

  localparam logic [2:0] OP_LB  = 3'd0;
  localparam logic [2:0] OP_LBU = 3'd1;
  localparam logic [2:0] OP_LH  = 3'd2;
  localparam logic [2:0] OP_LHU = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_SB  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SW  = 3'd7;

  typedef enum logic [1:0] {IDLE, ACCESS, LOAD_DATA, RESP} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [1:0]  boff_q, boff_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  function automatic logic [2:0] op_size(input logic [2:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd4;
    endcase
  endfunction

  function automatic logic is_store(input logic [2:0] op);
    return op >= OP_SB;
  endfunction

  // Last byte computed in 33 bits so addresses near 2^32 cannot wrap back in range.
  function automatic logic access_err(input logic [2:0] op, input logic [31:0] addr);
    logic [2:0]  sz;
    logic [32:0] last;
    logic        misal;
    sz    = op_size(op);
    last  = {1'b0, addr} + {30'd0, sz} - 33'd1;
    misal = ((sz == 3'd2) && addr[0]) || ((sz == 3'd4) && (addr[1:0] != 2'b00));
    return misal || (last >= 33'(MEM_BYTES));
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] op, input logic [1:0] b);
    case (op_size(op))
      3'd1:    return 4'b0001 << b;
      3'd2:    return 4'b0011 << b;
      default: return 4'b1111;
    endcase
  endfunction

  // Lane k carries the byte destined for mem_address+k; wdata is right-justified big-endian.
  function automatic logic [31:0] store_data(input logic [2:0] op, input logic [1:0] b,
                                             input logic [31:0] wd);
    logic [31:0] d;
    d = '0;
    case (op_size(op))
      3'd1: d[{b, 3'b000} +: 8] = wd[7:0];
      3'd2: begin
        d[{b, 3'b000} +: 8]         = wd[15:8];
        d[{b | 2'b01, 3'b000} +: 8] = wd[7:0];
      end
      default: d = {wd[7:0], wd[15:8], wd[23:16], wd[31:24]};
    endcase
    return d;
  endfunction

  // Read data is big-endian: byte k of the word sits at bit offset 8*(3-k).
  function automatic logic [31:0] load_extract(input logic [2:0] op, input logic [1:0] b,
                                               input logic [31:0] rd);
    logic signed [7:0]  by;
    logic signed [15:0] hw;
    by = rd[{~b, 3'b000} +: 8];
    hw = {by, rd[{~(b | 2'b01), 3'b000} +: 8]};
    case (op)
      OP_LB:   return 32'(by);
      OP_LBU:  return {24'd0, by};
      OP_LH:   return 32'(hw);
      OP_LHU:  return {16'd0, hw};
      default: return rd;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= '0;
      boff_q  <= '0;
      maddr_q <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      boff_q  <= boff_d;
      maddr_q <= maddr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    boff_d  = boff_q;
    maddr_d = maddr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          boff_d  = bus.req_addr[1:0];
          wdata_d = bus.req_wdata;
          rdata_d = '0;
          err_d   = access_err(bus.req_op, bus.req_addr);
          // A rejected request never reaches memory, so the bus address keeps its old value.
          if (!err_d) maddr_d = {bus.req_addr[31:2], 2'b00};
          state_d = err_d ? RESP : ACCESS;
        end
      end
      ACCESS:    state_d = is_store(op_q) ? RESP : LOAD_DATA;
      LOAD_DATA: begin
        rdata_d = load_extract(op_q, boff_q, bus.mem_rd_data);
        state_d = RESP;
      end
      RESP:      if (bus.resp_ready) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Strobes decode straight from the state register so an async reset drops them at once.
  always_comb begin
    bus.req_ready   = (state_q == IDLE);
    bus.resp_valid  = (state_q == RESP);
    bus.resp_rdata  = rdata_q;
    bus.resp_err    = err_q;
    bus.mem_address = maddr_q;
    bus.mem_wr_en   = 1'b0;
    bus.mem_read_en = 1'b0;
    bus.mem_byte_en = 4'b0000;
    bus.mem_wr_data = '0;
    if (state_q == ACCESS) begin
      if (is_store(op_q)) begin
        bus.mem_wr_en   = 1'b1;
        bus.mem_byte_en = store_be(op_q, boff_q);
        bus.mem_wr_data = store_data(op_q, boff_q, wdata_q);
      end else begin
        bus.mem_read_en = 1'b1;
        bus.mem_byte_en = 4'b1111;
      end
    end
  end

endmodule

// File: tb/tb_mips_load_store_unit.sv
// Bench for mips_load_store_unit: byte-array reference model plus a memory with one-cycle read latency.
`timescale 1ns/1ps
module tb_mips_load_store_unit;
  localparam int MEM_BYTES = 4096;
  localparam logic [2:0] LB = 3'd0, LBU = 3'd1, LH = 3'd2, LHU = 3'd3, LW = 3'd4,
                         SB = 3'd5, SH = 3'd6, SW = 3'd7;

  logic clk = 1'b0;
  logic rst_n;
  mips_load_store_unit_if bus();

  mips_load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  function automatic logic [7:0] init_byte(input int i);
    if (i >= 16 && i < 64) return 8'h00;
    return 8'((i * 113 + 29) ^ (i >> 3));
  endfunction

  // Physical memory: writes land at the clock edge, reads return data one cycle later.
  logic [7:0] phys [MEM_BYTES];
  initial begin
    for (int i = 0; i < MEM_BYTES; i++) phys[i] = init_byte(i);
    bus.mem_rd_data = 32'hDEADBEEF;
    forever begin
      @(posedge clk);
      if (bus.mem_wr_en)
        for (int k = 0; k < 4; k++)
          if (bus.mem_byte_en[k])
            phys[int'(bus.mem_address[11:0]) + k] = bus.mem_wr_data[8*k +: 8];
      if (bus.mem_read_en) begin
        int a;
        a = int'(bus.mem_address[11:0]);
        bus.mem_rd_data <= {phys[a], phys[a+1], phys[a+2], phys[a+3]};
      end else begin
        bus.mem_rd_data <= $urandom;
      end
    end
  end

  typedef struct {
    logic [2:0]  op;
    logic [31:0] addr;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd;
    int          acc;
  } txn_t;

  logic [7:0] ref_mem [MEM_BYTES];

  // Reference: an access covers `size` consecutive bytes, big-endian, low bytes of wdata.
  task automatic model_accept(input logic [2:0] op, input logic [31:0] addr,
                              input logic [31:0] wdata, output txn_t t);
    int     size;
    longint last;
    longint v;
    size    = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
    last    = longint'(addr) + size - 1;
    t.op    = op;
    t.addr  = addr;
    t.rdata = '0;
    t.be    = '0;
    t.wd    = '0;
    t.acc   = 0;
    t.err   = (last >= MEM_BYTES) || ((addr % size) != 0);
    if (!t.err) begin
      if (op >= SB) begin
        for (int i = 0; i < size; i++) begin
          int         a;
          logic [7:0] by;
          a  = int'(addr) + i;
          by = 8'(wdata >> (8 * (size - 1 - i)));
          ref_mem[a] = by;
          t.be[a % 4] = 1'b1;
          t.wd[8*(a % 4) +: 8] = by;
        end
      end else begin
        v = 0;
        for (int i = 0; i < size; i++) v = v * 256 + ref_mem[int'(addr) + i];
        if ((op == LB || op == LH) && v >= (longint'(1) << (8*size - 1)))
          v -= longint'(1) << (8*size);
        t.rdata = 32'(v);
        t.be    = 4'hF;
      end
    end
  endtask

  // Cycle-by-cycle compare of every DUT output against the reference transaction in flight.
  initial begin
    txn_t        t;
    bit          busy;
    int          cyc, k, lat;
    logic        acc, rv, st;
    logic [31:0] last_maddr;
    busy = 0;
    cyc = 0;
    last_maddr = '0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = init_byte(i);
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_wr_en", 32'(bus.mem_wr_en), 32'd0);
        chk("rst_read_en", 32'(bus.mem_read_en), 32'd0);
        chk("rst_byte_en", 32'(bus.mem_byte_en), 32'd0);
        chk("rst_address", bus.mem_address, 32'd0);
        chk("rst_wr_data", bus.mem_wr_data, 32'd0);
        busy = 0;
        last_maddr = '0;
      end else begin
        acc = 1'b0;
        rv  = 1'b0;
        st  = 1'b0;
        if (busy) begin
          k   = cyc - t.acc;
          st  = (t.op >= SB);
          lat = t.err ? 1 : (st ? 2 : 3);
          acc = !t.err && (k == 1);
          rv  = (k >= lat);
        end
        chk("req_ready", 32'(bus.req_ready), 32'(!busy));
        chk("resp_valid", 32'(bus.resp_valid), 32'(rv));
        chk("mem_wr_en", 32'(bus.mem_wr_en), 32'(acc && st));
        chk("mem_read_en", 32'(bus.mem_read_en), 32'(acc && !st));
        chk("mem_byte_en", 32'(bus.mem_byte_en), acc ? 32'(t.be) : 32'd0);
        chk("mem_wr_data", bus.mem_wr_data, acc ? t.wd : 32'd0);
        chk("mem_address", bus.mem_address, last_maddr);
        if (rv) begin
          chk("resp_rdata", bus.resp_rdata, t.rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(t.err));
        end
        if (busy && rv && bus.resp_ready) begin
          busy = 0;
        end else if (!busy && bus.req_valid) begin
          model_accept(bus.req_op, bus.req_addr, bus.req_wdata, t);
          t.acc = cyc;
          busy  = 1;
          if (!t.err) last_maddr = {t.addr[31:2], 2'b00};
        end
      end
    end
  end

  // Driver tasks are entered one time unit after a rising edge.
  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) timeout_fail("accept_timeout");
    @(posedge clk);
    #1;
  endtask

  task automatic wait_resp(output int lat, output logic strobe, output logic [3:0] be,
                           output logic [31:0] wd);
    lat = 0;
    strobe = 1'b0;
    be = '0;
    wd = '0;
    do begin
      @(negedge clk);
      lat++;
      if (bus.mem_wr_en || bus.mem_read_en) begin
        strobe = 1'b1;
        be     = bus.mem_byte_en;
        wd     = bus.mem_wr_data;
      end
    end while (!bus.resp_valid && lat < 10);
    if (!bus.resp_valid) timeout_fail("resp_timeout");
  endtask

  task automatic finish_resp(input int rdly);
    repeat (rdly) @(posedge clk);
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
  endtask

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                        input int rdly, output logic [31:0] rd, output logic er, output int lat,
                        output logic strobe, output logic [3:0] be, output logic [31:0] wd);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    wait_accept();
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    wait_resp(lat, strobe, be, wd);
    rd = bus.resp_rdata;
    er = bus.resp_err;
    finish_resp(rdly);
  endtask

  task automatic expect_txn(input string name, input logic [2:0] op, input logic [31:0] addr,
                            input logic [31:0] wdata, input int e_lat, input logic e_err,
                            input logic [31:0] e_rd, input logic [3:0] e_be,
                            input logic [31:0] e_wd);
    logic [31:0] rd, wd;
    logic        er, strobe;
    logic [3:0]  be;
    int          lat;
    do_req(op, addr, wdata, 1, rd, er, lat, strobe, be, wd);
    chk({name, "_lat"}, 32'(lat), 32'(e_lat));
    chk({name, "_err"}, 32'(er), 32'(e_err));
    chk({name, "_rdata"}, rd, e_rd);
    chk({name, "_strobe"}, 32'(strobe), 32'(!e_err));
    chk({name, "_be"}, 32'(be), 32'(e_be));
    chk({name, "_wd"}, wd, e_wd);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, wd, rd0, addr;
    logic        er, strobe;
    logic [3:0]  be;
    logic [2:0]  op;
    int          lat, size, r;

    rst_n = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op = '0;
    bus.req_addr = '0;
    bus.req_wdata = '0;
    bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    expect_txn("sw_10", SW, 32'h10, 32'h11223344, 2, 1'b0, 32'h0, 4'hF, 32'h44332211);
    expect_txn("lw_10", LW, 32'h10, 32'h0, 3, 1'b0, 32'h11223344, 4'hF, 32'h0);
    expect_txn("sb_21", SB, 32'h21, 32'h123456AB, 2, 1'b0, 32'h0, 4'b0010, 32'h0000AB00);
    expect_txn("lb_21", LB, 32'h21, 32'h0, 3, 1'b0, 32'hFFFFFFAB, 4'hF, 32'h0);
    expect_txn("lbu_21", LBU, 32'h21, 32'h0, 3, 1'b0, 32'h000000AB, 4'hF, 32'h0);
    expect_txn("sh_32", SH, 32'h32, 32'h00008001, 2, 1'b0, 32'h0, 4'b1100, 32'h01800000);
    expect_txn("lh_32", LH, 32'h32, 32'h0, 3, 1'b0, 32'hFFFF8001, 4'hF, 32'h0);
    expect_txn("lhu_32", LHU, 32'h32, 32'h0, 3, 1'b0, 32'h00008001, 4'hF, 32'h0);
    expect_txn("lh_33", LH, 32'h33, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0);
    expect_txn("lw_06", LW, 32'h06, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0);
    expect_txn("lw_ffc", LW, 32'hFFC, 32'h0, 3, 1'b0,
               {init_byte(12'hFFC), init_byte(12'hFFD), init_byte(12'hFFE), init_byte(12'hFFF)},
               4'hF, 32'h0);
    expect_txn("lw_1000", LW, 32'h1000, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0);
    expect_txn("sb_1000", SB, 32'h1000, 32'h5A, 1, 1'b1, 32'h0, 4'h0, 32'h0);
    expect_txn("sh_fff", SH, 32'hFFF, 32'h1234, 1, 1'b1, 32'h0, 4'h0, 32'h0);
    expect_txn("sb_fff", SB, 32'hFFF, 32'h77, 2, 1'b0, 32'h0, 4'b1000, 32'h77000000);
    expect_txn("lw_wrap", LW, 32'hFFFFFFFC, 32'h0, 1, 1'b1, 32'h0, 4'h0, 32'h0);

    // Backpressure: a second request waits in RESP and must only be taken after the handshake.
    bus.req_valid = 1'b1;
    bus.req_op    = LW;
    bus.req_addr  = 32'h10;
    bus.req_wdata = 32'h0;
    wait_accept();
    bus.req_op    = LHU;
    bus.req_addr  = 32'h32;
    bus.req_wdata = $urandom;
    wait_resp(lat, strobe, be, wd);
    chk("bp_lat", 32'(lat), 32'd3);
    rd0 = bus.resp_rdata;
    chk("bp_rdata", rd0, 32'h11223344);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_rdata", bus.resp_rdata, rd0);
      chk("bp_hold_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
    end
    @(posedge clk);
    #1 bus.resp_ready = 1'b1;
    @(posedge clk);
    #1 bus.resp_ready = 1'b0;
    chk("bp_idle_ready", 32'(bus.req_ready), 32'd1);
    chk("bp_idle_valid", 32'(bus.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    chk("bp_accepted", 32'(bus.req_ready), 32'd0);
    bus.req_valid = 1'b0;
    wait_resp(lat, strobe, be, wd);
    chk("bp2_lat", 32'(lat), 32'd3);
    chk("bp2_rdata", bus.resp_rdata, 32'h00008001);
    finish_resp(0);

    // Reset asserted while the load strobe is on the bus.
    bus.req_valid = 1'b1;
    bus.req_op    = LW;
    bus.req_addr  = 32'h10;
    wait_accept();
    bus.req_valid = 1'b0;
    chk("rst_mid_read_before", 32'(bus.mem_read_en), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_read_drop", 32'(bus.mem_read_en), 32'd0);
    chk("rst_mid_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rst_mid_no_resp", 32'(bus.resp_valid), 32'd0);
    chk("rst_mid_ready_after", 32'(bus.req_ready), 32'd1);

    for (int n = 0; n < 300; n++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      op   = 3'($urandom);
      size = (op == LB || op == LBU || op == SB) ? 1 : (op == LH || op == LHU || op == SH) ? 2 : 4;
      r    = int'($urandom_range(0, 9));
      if (r < 6)       addr = $urandom_range(0, MEM_BYTES - 1);
      else if (r < 8)  addr = MEM_BYTES - $urandom_range(1, 8);
      else if (r == 8) addr = $urandom;
      else             addr = 32'hFFFFFFFF - $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) addr = addr & ~(32'(size) - 32'd1);
      do_req(op, addr, $urandom, int'($urandom_range(0, 3)), rd, er, lat, strobe, be, wd);
    end

    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
